// File: rtl/bayer_mosaic_tx.sv
// -----------------------------------------------------------------------------
// bayer_mosaic_tx
//   Converts a full-RGB pixel stream into a single-channel RGGB Bayer RAW
//   stream. Each output sample carries its row/column parity so that it can
//   feed the raw input path of the demosaic pipeline directly.
//   Both sides use valid/ready handshakes. A main output register plus one
//   skid register sustain one pixel per clock. s_ready is a register, so no
//   combinational path runs from m_ready to s_ready.
//
// Ports
//   CLK, RST_N          clock, synchronous active-low reset
//   s_valid / s_ready   input handshake
//   s_r, s_g, s_b       input RGB components (DW bits each)
//   s_sof, s_eol        input start-of-frame / end-of-line markers
//   m_valid / m_ready   output handshake
//   m_raw               Bayer sample (DW bits)
//   m_x, m_y            column / row parity of the sample
//   m_sof, m_eol        first pixel of frame / last pixel of line (from counters)
//   err_line            one-cycle pulse when the input line length is wrong
// -----------------------------------------------------------------------------
module bayer_mosaic_tx #(
  parameter int DW    = 10,
  parameter int H_ACT = 1920,
  parameter int V_ACT = 1080
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_r,
  input  logic [DW-1:0] s_g,
  input  logic [DW-1:0] s_b,
  input  logic          s_sof,
  input  logic          s_eol,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [DW-1:0] m_raw,
  output logic          m_x,
  output logic          m_y,
  output logic          m_sof,
  output logic          m_eol,
  output logic          err_line
);

  localparam int XW = (H_ACT > 1) ? $clog2(H_ACT) : 1;
  localparam int YW = (V_ACT > 1) ? $clog2(V_ACT) : 1;

  typedef struct packed {
    logic [DW-1:0] raw;
    logic          y;
    logic          x;
    logic          sof;
    logic          eol;
  } beat_t;

  logic [XW-1:0] x_cnt_q, x_cnt_d;
  logic [YW-1:0] y_cnt_q, y_cnt_d;
  logic          main_valid_q, main_valid_d;
  beat_t         main_q, main_d;
  logic          skid_valid_q, skid_valid_d;
  beat_t         skid_q;
  logic          s_ready_q, s_ready_d;
  logic          err_q, err_d;

  logic [XW-1:0] pos_x;
  logic [YW-1:0] pos_y;
  logic          x_last, y_last, line_end;
  logic          accept, main_free, skid_load;
  beat_t         in_beat;

  assign accept    = s_valid & s_ready_q;
  // The main register can take a new beat if it is empty now or drains at this edge.
  assign main_free = ~main_valid_q | m_ready;
  assign skid_load = accept & ~main_free;

  // Position of the pixel presented now. s_sof forces it to (0,0).
  always_comb begin
    pos_x    = s_sof ? '0 : x_cnt_q;
    pos_y    = s_sof ? '0 : y_cnt_q;
    x_last   = (pos_x == XW'(H_ACT - 1));
    y_last   = (pos_y == YW'(V_ACT - 1));
    line_end = x_last | s_eol;

    in_beat     = '0;
    in_beat.x   = pos_x[0];
    in_beat.y   = pos_y[0];
    in_beat.sof = (pos_x == '0) && (pos_y == '0);
    in_beat.eol = x_last;
    unique case ({pos_y[0], pos_x[0]})
      2'd0:    in_beat.raw = s_r;
      2'd3:    in_beat.raw = s_b;
      default: in_beat.raw = s_g;
    endcase
  end

  // Next-state logic for counters, pipeline registers and status.
  // NOTE: every signal gets a default at the top of the block so that no
  // path leaves a value unassigned. That would infer a latch.
  always_comb begin
    x_cnt_d      = x_cnt_q;
    y_cnt_d      = y_cnt_q;
    main_valid_d = main_valid_q;
    main_d       = main_q;
    skid_valid_d = skid_valid_q;

    if (accept) begin
      if (line_end) begin
        x_cnt_d = '0;
        y_cnt_d = y_last ? '0 : pos_y + YW'(1);
      end else begin
        x_cnt_d = pos_x + XW'(1);
        y_cnt_d = pos_y;
      end
    end

    if (main_free) begin
      // The skid entry is older than any new beat, so it goes first. When it is
      // occupied s_ready is low, so no beat is accepted in the same cycle.
      main_valid_d = skid_valid_q | accept;
      if (skid_valid_q) begin
        main_d = skid_q;
      end else if (accept) begin
        main_d = in_beat;
      end
      skid_valid_d = 1'b0;
    end else if (accept) begin
      skid_valid_d = 1'b1;
    end

    // A short line (eol before the last column) or a long line (no eol at the
    // last column) is flagged. The counters still wrap as usual.
    err_d     = accept & (x_last ^ s_eol);
    s_ready_d = ~skid_valid_d;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples values from before the clock edge.
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      x_cnt_q      <= '0;
      y_cnt_q      <= '0;
      main_valid_q <= 1'b0;
      main_q       <= '0;
      skid_valid_q <= 1'b0;
      s_ready_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      x_cnt_q      <= x_cnt_d;
      y_cnt_q      <= y_cnt_d;
      main_valid_q <= main_valid_d;
      main_q       <= main_d;
      skid_valid_q <= skid_valid_d;
      s_ready_q    <= s_ready_d;
      err_q        <= err_d;
    end
  end

  // NOTE: the skid payload has no reset. Its valid bit decides whether the
  // payload is ever used, so a reset would only add load on the reset net.
  always_ff @(posedge CLK) begin
    if (skid_load) begin
      skid_q <= in_beat;
    end
  end

  assign s_ready  = s_ready_q;
  assign m_valid  = main_valid_q;
  assign m_raw    = main_q.raw;
  assign m_x      = main_q.x;
  assign m_y      = main_q.y;
  assign m_sof    = main_q.sof;
  assign m_eol    = main_q.eol;
  assign err_line = err_q;

endmodule

// File: doc/bayer_mosaic_tx.md
# bayer_mosaic_tx

Re-mosaics a full-RGB pixel stream into a single-channel RGGB Bayer RAW stream, tagging each output pixel with its row/column parity (Y, X) so the stream can drive the demosaic pipeline's raw input path. It sits between the test-pattern / frame-source logic and the line-buffer front end of the demosaic chain. This closes the loop RGB → RAW → RGB for self-test and regression. Both sides use valid/ready handshakes, and a two-entry skid buffer gives full throughput without a combinational ready path.

## Interface
- DW, 10, pixel component width
- H_ACT, 1920, active pixels per line (≥2)
- V_ACT, 1080, active lines per frame (≥2)

- CLK  in  1  clock
- RST_N  in  1  reset; synchronous, active-low
- s_valid  in  1  input pixel valid
- s_ready  out  1  block can accept input
- s_r, s_g, s_b  in  DW each  input RGB components
- s_sof  in  1  start of frame; marks pixel (0,0)
- s_eol  in  1  last pixel of line
- m_valid  out  1  output RAW pixel valid
- m_ready  in  1  downstream accepts
- m_raw  out  DW  Bayer sample
- m_x  out  1  column parity (X)
- m_y  out  1  row parity (Y)
- m_sof  out  1  first pixel of frame
- m_eol  out  1  last pixel of line (counter-derived)
- err_line  out  1  one-cycle pulse on line-length mismatch

## Operation
- The input is accepted on a handshake: s_valid & s_ready.
- Position counters:
  - x_cnt counts 0..H_ACT-1; y_cnt counts 0..V_ACT-1.
  - Both advance only on an accepted input.
- Position of the accepted pixel:
  - If s_sof=1, the pixel is at (0,0), regardless of the counters.
  - Otherwise it is at (x_cnt, y_cnt).
- Counter update after an accepted pixel at (x, y):
  - Line end is x==H_ACT-1 or s_eol=1. At line end, x_cnt←0 and y_cnt←(y==V_ACT-1 ? 0 : y+1).
  - Otherwise x_cnt←x+1, y_cnt←y.
- Channel select, RGGB pattern, {Y,X} = {y[0], x[0]}:
  - 0 → m_raw = R
  - 1 → G
  - 2 → G
  - 3 → B
- Output tags:
  - m_x = x[0] and m_y = y[0].
  - m_sof = 1 iff the position is (0,0).
  - m_eol = 1 iff x==H_ACT-1.
- err_line pulses for one cycle, one cycle after the accept, in either case:
  - s_eol=1 with x≠H_ACT-1 (short line);
  - x==H_ACT-1 with s_eol=0 (long line or missing eol).
  The line still wraps as defined above.
- Skid buffer: a main output register plus one skid register.
  - s_ready = !skid_full, registered.
  - If the main register is occupied and not drained, the accepted beat goes into the skid register.
  - The skid register moves to the main register when the main register drains.
  - Data is never dropped or duplicated, and order is preserved.
- Reset (RST_N=0 at a clock edge) clears everything:
  - x_cnt, y_cnt, both registers' valid bits;
  - m_valid=0, m_raw=0, m_x=0, m_y=0, m_sof=0, m_eol=0, err_line=0, s_ready=0.
  - s_ready goes to 1 on the first edge with RST_N=1.
  - A reset mid-frame discards buffered beats; the next accepted pixel is at (0,0) even without s_sof.

## Timing
- Latency is 1 cycle: a beat accepted at edge k appears on m_* after edge k when the output is empty or draining at k.
- Throughput is 1 pixel/cycle with m_ready held high.
- Backpressure: when m_ready=0 with the main register full, one more beat is absorbed into the skid register, then s_ready=0 from the following cycle.
- s_ready returns to 1 the cycle after the skid register empties.
- m_* are held stable while m_valid=1 and m_ready=0.
- When both registers are full, simultaneous input and output is impossible because s_ready=0. When only the main register is full and a drain and an accept happen in the same edge, the new beat goes directly into the main register.
- err_line is aligned with the output of the offending beat when there is no backpressure; otherwise it is aligned with the accept, k+1.
- All outputs are registered; there is no combinational input→output path.

## Test plan
- RESET: hold RST_N=0 for 3 cycles, then release → all outputs 0 during reset; s_ready=1 one edge after release; first pixel lands at (0,0).
- BAYER MAP, H_ACT=4, V_ACT=2, m_ready=1, pixel (r,g,b) = (100+i, 200+i, 300+i) → m_raw = 100, 201, 102, 203 on row 0 and 204, 305, 206, 307 on row 1; {m_y,m_x} = 0, 1, 0, 1, 2, 3, 2, 3; m_eol on pixels 3 and 7; m_sof only on pixel 0; y wraps to 0 at the next frame.
- BACKPRESSURE: continuous s_valid, m_ready toggling 1,0,0,1,1,0,… for 64 beats → the output sequence equals the input sequence exactly; s_ready deasserts no later than one cycle after the skid register fills; m_* are stable while stalled.
- LINE ERRORS, H_ACT=4: eol on the 3rd pixel → err_line pulse and the next pixel has y=1, x=0. No eol on the 4th pixel → err_line pulse, wrap anyway.
- SOF RESYNC: s_sof asserted at counter position (2,1) → that pixel is emitted with m_sof=1, {m_y,m_x}=0, m_raw=R; counters continue from (1,0).
- RESET MID-FRAME: RST_N=0 for 1 cycle with both registers full → m_valid=0 after the edge, buffered beats discarded; the next accepted pixel is at (0,0).
